imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write side of the instruction memory: receives a program image as a byte stream
//  (valid/ready), assembles big-endian 32-bit words and drives the InstMem write port
//  (WriteEnable/WriteData plus a byte address) that the fetch stage reads each negedge.
//  Holds the PC via PCEnable (drives stallMuxSelector; 0 = hold) until a checksum-verified
//  image is loaded.
// PARAMETERS
//  MEM_DEPTH  256  instruction memory depth in words; max legal word count
//  BASE_ADDR  0    byte address of the first written word (multiple of 4)
// PORTS
//  Clk          in   1   clock; all logic on posedge Clk
//  Reset        in   1   synchronous, active-high reset
//  Start        in   1   1-cycle pulse: begin a load (honoured in IDLE and ERR only)
//  ByteIn       in   8   stream byte
//  ByteValid    in   1   ByteIn valid
//  ByteReady    out  1   loader accepts ByteIn; transfer = ByteValid & ByteReady
//  WriteEnable  out  1   1-cycle instruction memory write strobe
//  WriteAddress out  32  byte address of write (memory index = WriteAddress>>2)
//  WriteData    out  32  instruction word
//  PCEnable     out  1   0 = hold PC, 1 = PC may advance
//  LoadDone     out  1   image loaded and checksum matched (sticky)
//  LoadError    out  1   count overflow or checksum mismatch (sticky)
// BEHAVIOUR
//  - Reset (sync, active-high): state IDLE; ByteReady=0, WriteEnable=0,
//    WriteAddress=BASE_ADDR, WriteData=0, PCEnable=0, LoadDone=0, LoadError=0,
//    byte counter=0, word counter=0, running XOR=0. All outputs are registered.
//  - Stream format: CNT_HI, CNT_LO (16-bit word count N, big-endian), 4*N data bytes
//    (first byte -> bits [31:24]), one checksum byte = XOR of all preceding bytes incl. count.
//  - States: IDLE -Start-> CNT_HI -byte-> CNT_LO -byte-> DATA (N>0) | CSUM (N=0) | ERR (N>MEM_DEPTH);
//    DATA -Nth word's 4th byte-> CSUM; CSUM -byte-> DONE (match) | ERR (mismatch).
//  - ByteReady=1 exactly in CNT_HI, CNT_LO, DATA, CSUM; 0 in IDLE, DONE, ERR. A byte
//    presented with Start in IDLE is not accepted.
//  - Start clears XOR, counters, LoadError; WriteAddress reloads BASE_ADDR.
//  - Word write: cycle after the 4th byte of a word is accepted, WriteEnable=1 for exactly
//    one cycle with WriteData = assembled word, WriteAddress = current address; address
//    increments by 4 in the following cycle. Next word's bytes may be accepted back-to-back
//    (no bubble), so a byte each cycle yields one write every 4 cycles.
//  - Word N's write strobe occurs the cycle the loader enters CSUM; never after CSUM byte.
//  - DONE: LoadDone=1, PCEnable=1, held until Reset; Start ignored.
//  - ERR: LoadError=1, PCEnable=0; held until Reset or Start (restart). Words already
//    written stay written (no rollback).
//  - Start in CNT_HI/CNT_LO/DATA/CSUM ignored. ByteValid low simply stalls the state machine.
//  - Reset mid-load: aborts immediately, no WriteEnable in the Reset cycle or after.
//  - WriteAddress wraps modulo 2^32 (unreachable for legal N <= MEM_DEPTH).
// TESTING
//  1. Reset, Start, stream 00 01 8E 71 00 14 xx (xx=XOR) -> one write 0x8E710014 @0x0,
//     LoadDone=1, PCEnable=1, LoadError=0.
//  2. N=3 words streamed back-to-back every cycle -> writes @0x0,0x4,0x8 four cycles
//     apart, each WriteEnable exactly 1 cycle, correct big-endian data.
//  3. N=2 with checksum byte flipped -> LoadError=1, PCEnable=0, LoadDone=0; Start then a
//     good image -> LoadDone=1, LoadError=0.
//  4. Count 0x0101 (257 > 256) -> ERR right after CNT_LO, no WriteEnable ever asserted.
//  5. Random ByteValid gaps plus Reset asserted after 6 data bytes -> exactly 1 write,
//     outputs return to reset values next cycle, ByteReady=0 until Start.
//  6. N=0, checksum 00^00=00 -> no writes, LoadDone=1; Start while in DONE ignored.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: valid/ready byte stream carrying a program image into the loader.
interface imem_loader_if;
    logic [7:0] ByteIn;
    logic       ByteValid;
    logic       ByteReady;
    modport master (output ByteIn, output ByteValid, input ByteReady);
    modport slave (input ByteIn, input ByteValid, output ByteReady);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a checksummed big-endian byte stream into instruction memory writes and releases the PC once loaded.
module imem_loader #(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    imem_loader_if.slave stream,
    output logic         WriteEnable,
    output logic [31:0]  WriteAddress,
    output logic [31:0]  WriteData,
    output logic         PCEnable,
    output logic         LoadDone,
    output logic         LoadError
);
    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR} state_t;
    localparam logic [16:0] MAX_WORDS = 17'(MEM_DEPTH);
    state_t      r_state;
    logic [15:0] r_count;
    logic [15:0] r_words;
    logic [1:0]  r_bcnt;
    logic [23:0] r_shift;
    logic [7:0]  r_xor;
    logic        w_xfer;
    logic [15:0] w_n;
    logic [15:0] w_words_next;
    logic [31:0] w_word;
    assign w_xfer       = stream.ByteValid & stream.ByteReady;
    assign w_n          = {r_count[15:8], stream.ByteIn};
    assign w_word       = {r_shift, stream.ByteIn};
    assign w_words_next = r_words + 16'd1;
    // ByteReady is set alongside every state change so it always mirrors the state it enters
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state          <= IDLE;
            stream.ByteReady <= 1'b0;
            WriteEnable      <= 1'b0;
            WriteAddress     <= BASE_ADDR;
            WriteData        <= 32'h0;
            PCEnable         <= 1'b0;
            LoadDone         <= 1'b0;
            LoadError        <= 1'b0;
            r_count          <= 16'h0;
            r_words          <= 16'h0;
            r_bcnt           <= 2'd0;
            r_shift          <= 24'h0;
            r_xor            <= 8'h0;
        end else begin
            WriteEnable <= 1'b0;
            if (WriteEnable)
                WriteAddress <= WriteAddress + 32'd4;
            case (r_state)
                IDLE, ERR: if (Start) begin
                    r_state          <= CNT_HI;
                    stream.ByteReady <= 1'b1;
                    LoadError        <= 1'b0;
                    WriteAddress     <= BASE_ADDR;
                    r_count          <= 16'h0;
                    r_words          <= 16'h0;
                    r_bcnt           <= 2'd0;
                    r_xor            <= 8'h0;
                end
                CNT_HI: if (w_xfer) begin
                    r_count[15:8] <= stream.ByteIn;
                    r_xor         <= r_xor ^ stream.ByteIn;
                    r_state       <= CNT_LO;
                end
                CNT_LO: if (w_xfer) begin
                    r_count[7:0] <= stream.ByteIn;
                    r_xor        <= r_xor ^ stream.ByteIn;
                    if ({1'b0, w_n} > MAX_WORDS) begin
                        r_state          <= ERR;
                        stream.ByteReady <= 1'b0;
                        LoadError        <= 1'b1;
                    end else begin
                        r_state <= (w_n == 16'h0) ? CSUM : DATA;
                    end
                end
                DATA: if (w_xfer) begin
                    r_xor   <= r_xor ^ stream.ByteIn;
                    r_bcnt  <= r_bcnt + 2'd1;
                    r_shift <= w_word[23:0];
                    if (r_bcnt == 2'd3) begin
                        WriteEnable <= 1'b1;
                        WriteData   <= w_word;
                        r_words     <= w_words_next;
                        if (w_words_next == r_count)
                            r_state <= CSUM;
                    end
                end
                CSUM: if (w_xfer) begin
                    stream.ByteReady <= 1'b0;
                    if (stream.ByteIn == r_xor) begin
                        r_state  <= DONE;
                        LoadDone <= 1'b1;
                        PCEnable <= 1'b1;
                    end else begin
                        r_state   <= ERR;
                        LoadError <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed streams against a byte-position model of the loader plus literal spot checks.
module tb_imem_loader;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        PCEnable;
    logic        LoadDone;
    logic        LoadError;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        chk_en = 1'b0;
    imem_loader_if bif();
    imem_loader #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .Clk(clk), .Reset(rst), .Start(start), .stream(bif.slave),
        .WriteEnable(WriteEnable), .WriteAddress(WriteAddress), .WriteData(WriteData),
        .PCEnable(PCEnable), .LoadDone(LoadDone), .LoadError(LoadError)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // model: outcome follows purely from how many bytes were accepted since Start
    logic        m_ready, m_we, m_done, m_err;
    logic [31:0] m_addr, m_wdata;
    logic [7:0]  m_bytes[$];
    always @(posedge clk) begin : model
        logic acc;
        logic [7:0] x;
        int p;
        int n;
        acc = bif.ByteValid && m_ready;
        if (rst) begin
            m_ready = 1'b0; m_we = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_addr = BASE; m_wdata = 32'h0; m_bytes.delete();
        end else begin
            if (m_we) m_addr = m_addr + 32'd4;
            m_we = 1'b0;
            if (!m_ready && !m_done && start) begin
                m_ready = 1'b1; m_err = 1'b0; m_addr = BASE; m_bytes.delete();
            end else if (acc) begin
                m_bytes.push_back(bif.ByteIn);
                p = m_bytes.size();
                n = (p >= 2) ? int'({16'h0, m_bytes[0], m_bytes[1]}) : 0;
                if (p == 2 && n > DEPTH) begin
                    m_ready = 1'b0; m_err = 1'b1;
                end else if (p > 2 && p <= 2 + 4 * n && (p - 2) % 4 == 0) begin
                    m_we = 1'b1;
                    m_wdata = {m_bytes[p-4], m_bytes[p-3], m_bytes[p-2], m_bytes[p-1]};
                end else if (p > 2 && p == 3 + 4 * n) begin
                    x = 8'h0;
                    for (int i = 0; i < p - 1; i++) x = x ^ m_bytes[i];
                    m_ready = 1'b0;
                    if (x == m_bytes[p-1]) m_done = 1'b1;
                    else m_err = 1'b1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    always @(negedge clk) if (chk_en) begin
        check("ByteReady", 32'(bif.ByteReady), 32'(m_ready));
        check("WriteEnable", 32'(WriteEnable), 32'(m_we));
        check("WriteAddress", WriteAddress, m_addr);
        if (m_we) check("WriteData", WriteData, m_wdata);
        check("LoadDone", 32'(LoadDone), 32'(m_done));
        check("LoadError", 32'(LoadError), 32'(m_err));
        check("PCEnable", 32'(PCEnable), 32'(m_done));
        if (WriteEnable === 1'b1) begin
            wr_addr.push_back(WriteAddress);
            wr_data.push_back(WriteData);
            wr_cyc.push_back(cyc);
        end
    end

    logic [7:0] stim[$];
    int gap_tab[6] = '{1, 0, 2, 0, 1, 3};

    task automatic clr_log();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; @(negedge clk); rst = 1'b0; clr_log();
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic build(input logic [15:0] n, input logic [31:0] w[$], input logic [7:0] flip);
        logic [7:0] x;
        stim.delete();
        stim.push_back(n[15:8]);
        stim.push_back(n[7:0]);
        foreach (w[i]) for (int k = 3; k >= 0; k--) stim.push_back(w[i][8*k +: 8]);
        x = 8'h0;
        foreach (stim[i]) x = x ^ stim[i];
        stim.push_back(x ^ flip);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        bif.ByteValid = 1'b0;
        repeat (gap) @(negedge clk);
        bif.ByteIn = b;
        bif.ByteValid = 1'b1;
        for (t = 0; t < 40 && bif.ByteReady !== 1'b1; t++) @(negedge clk);
        if (t == 40) begin
            checks++; failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted byte=%h", b);
        end
        @(negedge clk);
        bif.ByteValid = 1'b0;
    endtask

    task automatic send_stim(input int count, input bit gaps);
        for (int i = 0; i < count; i++) send(stim[i], gaps ? gap_tab[i % 6] : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; bif.ByteValid = 1'b0; bif.ByteIn = 8'h0;
        idle(2);
        rst = 1'b0;
        check("rst_ready", 32'(bif.ByteReady), 32'h0);
        check("rst_we", 32'(WriteEnable), 32'h0);
        check("rst_addr", WriteAddress, 32'h0);
        check("rst_data", WriteData, 32'h0);
        check("rst_pcen", 32'(PCEnable), 32'h0);
        check("rst_done", 32'(LoadDone), 32'h0);
        check("rst_err", 32'(LoadError), 32'h0);
        chk_en = 1'b1;

        // one word, first byte offered together with Start must wait for the next cycle
        bif.ByteIn = 8'h00; bif.ByteValid = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stim = '{8'h00, 8'h01, 8'h8E, 8'h71, 8'h00, 8'h14, 8'hEA};
        send_stim(7, 0);
        idle(3);
        check("t1_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check("t1_addr", wr_addr[0], 32'h0);
            check("t1_data", wr_data[0], 32'h8E710014);
        end
        check("t1_done", 32'(LoadDone), 32'h1);
        check("t1_pcen", 32'(PCEnable), 32'h1);
        check("t1_err", 32'(LoadError), 32'h0);

        // three words back-to-back
        do_reset(); pulse_start();
        build(16'd3, '{32'h11223344, 32'hA5A50F0F, 32'hDEADBEEF}, 8'h00);
        send_stim(stim.size(), 0);
        idle(3);
        check("t2_nwr", wr_addr.size(), 32'd3);
        if (wr_addr.size() == 3) begin
            check("t2_addr1", wr_addr[1], 32'h4);
            check("t2_addr2", wr_addr[2], 32'h8);
            check("t2_data0", wr_data[0], 32'h11223344);
            check("t2_data2", wr_data[2], 32'hDEADBEEF);
            check("t2_gap01", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
            check("t2_gap12", 32'(wr_cyc[2] - wr_cyc[1]), 32'd4);
        end
        check("t2_done", 32'(LoadDone), 32'h1);

        // bad checksum, then restart from the error state
        do_reset(); pulse_start();
        build(16'd2, '{32'h01020304, 32'hCAFEF00D}, 8'hFF);
        send_stim(stim.size(), 0);
        idle(2);
        check("t3_nwr", wr_addr.size(), 32'd2);
        check("t3_err", 32'(LoadError), 32'h1);
        check("t3_pcen", 32'(PCEnable), 32'h0);
        check("t3_done", 32'(LoadDone), 32'h0);
        clr_log(); pulse_start();
        build(16'd1, '{32'h13579BDF}, 8'h00);
        send_stim(stim.size(), 0);
        idle(2);
        check("t3b_done", 32'(LoadDone), 32'h1);
        check("t3b_err", 32'(LoadError), 32'h0);
        check("t3b_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) check("t3b_addr", wr_addr[0], 32'h0);

        // word count above memory depth
        do_reset(); pulse_start();
        send(8'h01, 0); send(8'h01, 0);
        bif.ByteIn = 8'h55; bif.ByteValid = 1'b1;
        idle(4);
        bif.ByteValid = 1'b0;
        check("t4_err", 32'(LoadError), 32'h1);
        check("t4_ready", 32'(bif.ByteReady), 32'h0);
        check("t4_nwr", wr_addr.size(), 32'd0);

        // reset in the middle of the second word
        do_reset(); pulse_start();
        build(16'd3, '{32'hF00DFACE, 32'h0BADC0DE, 32'h12345678}, 8'h00);
        send_stim(8, 1);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("t5_ready", 32'(bif.ByteReady), 32'h0);
        check("t5_we", 32'(WriteEnable), 32'h0);
        check("t5_addr", WriteAddress, 32'h0);
        check("t5_data", WriteData, 32'h0);
        idle(3);
        check("t5_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) check("t5_wdata", wr_data[0], 32'hF00DFACE);
        check("t5_ready2", 32'(bif.ByteReady), 32'h0);

        // empty image, Start in DONE has no effect
        do_reset(); pulse_start();
        stim = '{8'h00, 8'h00, 8'h00};
        send_stim(3, 0);
        idle(2);
        check("t6_done", 32'(LoadDone), 32'h1);
        check("t6_nwr", wr_addr.size(), 32'd0);
        bif.ByteIn = 8'h00; bif.ByteValid = 1'b1;
        pulse_start();
        idle(3);
        bif.ByteValid = 1'b0;
        check("t6_done2", 32'(LoadDone), 32'h1);
        check("t6_pcen", 32'(PCEnable), 32'h1);
        check("t6_ready", 32'(bif.ByteReady), 32'h0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
